// File: rtl/pipe_pkg.sv
//////////////////////////////////////////////////////////////////////////////
// pipe_pkg : shared ALU opcodes, widths and control bundle for the pipeline.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
`default_nettype none

package pipe_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_ADDU = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
//////////////////////////////////////////////////////////////////////////////
// fwd_unit : operand bypass select for one source register (EX > MEM > RF).
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
`default_nettype none

module fwd_unit #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] id_data,
    input  logic          ex_valid,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] ex_rd_addr,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_result,
    output logic [DW-1:0] value
);

    always_comb begin
        value = id_data;
        if (addr == '0) begin
            value = '0;
        end else if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd_addr == addr)) begin
            value = ex_result;
        end else if (mem_reg_write && (mem_rd_addr == addr)) begin
            value = mem_result;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//////////////////////////////////////////////////////////////////////////////
// id_ex_stage : ID/EX pipeline register with operand forwarding and load-use bubbles.
// Revision    : 1.0
//////////////////////////////////////////////////////////////////////////////
`default_nettype none

module id_ex_stage #(
    parameter int DW  = pipe_pkg::DW,
    parameter int AW  = pipe_pkg::AW,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [2:0]     id_op,
    input  logic [AW-1:0]  id_rs_addr,
    input  logic [AW-1:0]  id_rt_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_use_imm,
    input  logic           id_rt_used,
    input  logic [AW-1:0]  id_rd_addr,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic [DW-1:0]  ex_result,
    input  logic           mem_reg_write,
    input  logic [AW-1:0]  mem_rd_addr,
    input  logic [DW-1:0]  mem_result,
    input  logic           hold,
    input  logic           flush,
    output logic           stall_id,
    output logic           ex_valid,
    output logic [2:0]     ex_op,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [DW-1:0]  ex_rs_val_store,
    output logic [AW-1:0]  ex_rd_addr,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           ex_div_zero,
    output logic [SCW-1:0] stall_count
);

    import pipe_pkg::*;

    localparam logic [SCW-1:0] c_cnt_one = {{(SCW-1){1'b0}}, 1'b1};

    ctrl_t         r_ctrl;
    ctrl_t         w_id_ctrl;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;
    logic [DW-1:0] w_b;
    logic          w_lu;

    assign w_id_ctrl    = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
    assign ex_reg_write = r_ctrl.reg_write;
    assign ex_mem_read  = r_ctrl.mem_read;
    assign ex_mem_write = r_ctrl.mem_write;

    fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
        .addr          (id_rs_addr),
        .id_data       (id_rs_data),
        .ex_valid      (ex_valid),
        .ex_reg_write  (r_ctrl.reg_write),
        .ex_mem_read   (r_ctrl.mem_read),
        .ex_rd_addr    (ex_rd_addr),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .value         (w_fwd_rs)
    );

    fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
        .addr          (id_rt_addr),
        .id_data       (id_rt_data),
        .ex_valid      (ex_valid),
        .ex_reg_write  (r_ctrl.reg_write),
        .ex_mem_read   (r_ctrl.mem_read),
        .ex_rd_addr    (ex_rd_addr),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .value         (w_fwd_rt)
    );

    assign w_b = id_use_imm ? id_imm : w_fwd_rt;

    // A load in EX cannot be bypassed; its data only appears on mem_result a cycle later.
    assign w_lu = id_valid && ex_valid && r_ctrl.mem_read && (ex_rd_addr != '0) &&
                  ((ex_rd_addr == id_rs_addr) || (id_rt_used && (ex_rd_addr == id_rt_addr)));

    assign stall_id = !rst && (w_lu || hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid        <= 1'b0;
            ex_op           <= OP_NOP;
            ex_a            <= '0;
            ex_b            <= '0;
            ex_rs_val_store <= '0;
            ex_rd_addr      <= '0;
            r_ctrl          <= '0;
            ex_div_zero     <= 1'b0;
            stall_count     <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_op       <= OP_NOP;
            r_ctrl      <= '0;
            ex_div_zero <= 1'b0;
        end else if (hold) begin
            ex_valid <= ex_valid;
        end else if (w_lu) begin
            ex_valid    <= 1'b0;
            ex_op       <= OP_NOP;
            r_ctrl      <= '0;
            ex_div_zero <= 1'b0;
            if (stall_count != '1) begin
                stall_count <= stall_count + c_cnt_one;
            end
        end else begin
            ex_valid        <= id_valid;
            ex_op           <= id_valid ? id_op : OP_NOP;
            ex_a            <= w_fwd_rs;
            ex_b            <= w_b;
            ex_rs_val_store <= w_fwd_rt;
            ex_rd_addr      <= id_rd_addr;
            r_ctrl          <= id_valid ? w_id_ctrl : '0;
            ex_div_zero     <= id_valid && (id_op == OP_DIV) && (w_b == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//////////////////////////////////////////////////////////////////////////////
// tb_id_ex_stage : directed vector table plus async-reset sequence for id_ex_stage.
// Revision       : 1.0
//////////////////////////////////////////////////////////////////////////////
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_op;
    logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, ex_rd_addr;
    logic [15:0] id_rs_data, id_rt_data, id_imm, ex_result, mem_result;
    logic        id_use_imm, id_rt_used, id_reg_write, id_mem_read, id_mem_write;
    logic        mem_reg_write, hold, flush;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_div_zero;
    logic [2:0]  ex_op;
    logic [15:0] ex_a, ex_b, ex_rs_val_store, stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op(id_op),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rt_used(id_rt_used),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_result(ex_result), .mem_reg_write(mem_reg_write),
        .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .hold(hold), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rs_val_store(ex_rs_val_store), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_div_zero(ex_div_zero),
        .stall_count(stall_count)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [3:0]  rs, rt;
        logic [15:0] rsd, rtd, imm;
        logic        use_imm, rt_used;
        logic [3:0]  rd;
        logic        rw, mr, mw;
        logic [15:0] exr;
        logic        mrw;
        logic [3:0]  mrd;
        logic [15:0] mres;
        logic        hld, fls;
        logic        x_stall, x_valid;
        logic [2:0]  x_op;
        logic        x_rw, x_dz;
        logic [15:0] x_cnt;
        logic        x_chk;
        logic [15:0] x_a, x_b, x_st;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid;  id_op = v.op;
        id_rs_addr = v.rs;   id_rt_addr = v.rt;
        id_rs_data = v.rsd;  id_rt_data = v.rtd;
        id_imm = v.imm;      id_use_imm = v.use_imm;  id_rt_used = v.rt_used;
        id_rd_addr = v.rd;   id_reg_write = v.rw;
        id_mem_read = v.mr;  id_mem_write = v.mw;
        ex_result = v.exr;   mem_reg_write = v.mrw;
        mem_rd_addr = v.mrd; mem_result = v.mres;
        hold = v.hld;        flush = v.fls;
    endtask

    initial begin
        // valid op rs rt rsd rtd imm uimm rtu rd rw mr mw | exr mrw mrd mres | hold flush
        //   | x_stall x_valid x_op x_rw x_dz x_cnt x_chk x_a x_b x_st
        vt[0]  = '{1,3'b000,2,3,16'h0002,16'h0003,0,0,1,1,1,0,0, 16'h0000,0,0,0, 0,0, 0,1,3'b000,1,0,1'd0,1,16'h0002,16'h0003,16'h0003};
        vt[1]  = '{1,3'b001,1,3,16'h0000,16'h0003,0,0,1,4,1,0,0, 16'h0005,0,0,0, 0,0, 0,1,3'b001,1,0,0,1,16'h0005,16'h0003,16'h0003};
        vt[2]  = '{1,3'b000,2,3,16'h0007,16'h0001,0,0,1,1,1,0,0, 16'h9999,0,0,0, 0,0, 0,1,3'b000,1,0,0,1,16'h0007,16'h0001,16'h0001};
        vt[3]  = '{1,3'b101,1,0,16'h0000,16'h5555,0,0,1,5,1,0,0, 16'h0011,1,1,16'h0022, 0,0, 0,1,3'b101,1,0,0,1,16'h0011,16'h0000,16'h0000};
        vt[4]  = '{1,3'b000,5,0,16'h0100,16'h0000,16'h0004,1,0,2,1,1,0, 16'h0033,0,0,0, 0,0, 0,1,3'b000,1,0,0,1,16'h0033,16'h0004,16'h0000};
        vt[5]  = '{1,3'b000,2,3,16'h0000,16'h0001,0,0,1,6,1,0,0, 16'h6666,0,0,0, 0,0, 1,0,3'b111,0,0,1,0,0,0,0};
        vt[6]  = '{1,3'b000,2,3,16'h0000,16'h0001,0,0,1,6,1,0,0, 16'h7777,1,2,16'hBEEF, 0,0, 0,1,3'b000,1,0,1,1,16'hBEEF,16'h0001,16'h0001};
        vt[7]  = '{1,3'b011,3,0,16'h000A,16'h0000,16'h0000,1,0,7,1,0,0, 16'h4444,0,0,0, 0,0, 0,1,3'b011,1,1,1,1,16'h000A,16'h0000,16'h0000};
        vt[8]  = '{1,3'b011,3,0,16'h000A,16'h0000,16'h0003,1,0,7,1,0,0, 16'h4444,0,0,0, 0,0, 0,1,3'b011,1,0,1,1,16'h000A,16'h0003,16'h0000};
        vt[9]  = '{1,3'b000,1,2,16'h0001,16'h0002,0,0,1,3,1,0,0, 16'h0000,0,0,0, 1,1, 1,0,3'b111,0,0,1,0,0,0,0};
        vt[10] = '{1,3'b100,1,2,16'h00F0,16'h0FF0,0,0,1,8,1,0,0, 16'h0000,0,0,0, 0,0, 0,1,3'b100,1,0,1,1,16'h00F0,16'h0FF0,16'h0FF0};
        vt[11] = '{1,3'b001,9,10,16'h1234,16'h4321,0,0,1,9,0,0,1, 16'h0000,0,0,0, 1,0, 1,1,3'b100,1,0,1,1,16'h00F0,16'h0FF0,16'h0FF0};
        vt[12] = '{1,3'b011,9,10,16'h1234,16'h0000,0,0,1,9,0,1,0, 16'h0000,0,0,0, 1,0, 1,1,3'b100,1,0,1,1,16'h00F0,16'h0FF0,16'h0FF0};
        vt[13] = '{0,3'b010,8,8,16'hAAAA,16'h5555,0,0,1,9,1,0,0, 16'hFFFF,0,0,0, 1,0, 1,1,3'b100,1,0,1,1,16'h00F0,16'h0FF0,16'h0FF0};
        vt[14] = '{1,3'b000,0,0,16'h1111,16'h0000,16'h0010,1,0,0,1,1,0, 16'h2222,0,0,0, 0,0, 0,1,3'b000,1,0,1,1,16'h0000,16'h0010,16'h0000};
        vt[15] = '{1,3'b000,0,0,16'h5678,16'h9999,0,0,1,9,1,0,0, 16'h1234,0,0,0, 0,0, 0,1,3'b000,1,0,1,1,16'h0000,16'h0000,16'h0000};
        vt[16] = '{0,3'b000,1,2,16'h0001,16'h0002,0,0,1,3,1,0,0, 16'h0000,0,0,0, 0,0, 0,0,3'b111,0,0,1,0,0,0,0};

        // Reset state, with hold high to show stall_id is masked during reset.
        rst = 1'b1;
        drive(vt[16]);
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_id", 32'(stall_id), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_op",    32'(ex_op),    32'd7);
        chk("rst_ex_a",     32'(ex_a),     32'd0);
        chk("rst_count",    32'(stall_count), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_stall_id", i), 32'(stall_id), 32'(vt[i].x_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vt[i].x_valid));
            chk($sformatf("v%0d_ex_op", i), 32'(ex_op), 32'(vt[i].x_op));
            chk($sformatf("v%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(vt[i].x_rw));
            chk($sformatf("v%0d_ex_div_zero", i), 32'(ex_div_zero), 32'(vt[i].x_dz));
            chk($sformatf("v%0d_stall_count", i), 32'(stall_count), 32'(vt[i].x_cnt));
            if (vt[i].x_chk) begin
                chk($sformatf("v%0d_ex_a", i), 32'(ex_a), 32'(vt[i].x_a));
                chk($sformatf("v%0d_ex_b", i), 32'(ex_b), 32'(vt[i].x_b));
                chk($sformatf("v%0d_ex_store", i), 32'(ex_rs_val_store), 32'(vt[i].x_st));
            end
        end

        // Asynchronous reset mid-cycle while a valid load sits in EX.
        @(negedge clk);
        drive(vt[4]);
        @(posedge clk);
        #1;
        chk("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
        chk("pre_rst_mem_read", 32'(ex_mem_read), 32'd1);
        #2;
        hold = 1'b1;
        rst  = 1'b1;
        #1;
        chk("async_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_ex_op", 32'(ex_op), 32'd7);
        chk("async_rst_ex_a", 32'(ex_a), 32'd0);
        chk("async_rst_ex_b", 32'(ex_b), 32'd0);
        chk("async_rst_mem_read", 32'(ex_mem_read), 32'd0);
        chk("async_rst_rd_addr", 32'(ex_rd_addr), 32'd0);
        chk("async_rst_count", 32'(stall_count), 32'd0);
        chk("async_rst_stall_id", 32'(stall_id), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register and operand-issue logic that sits directly upstream of the 16-bit ALU.
- Captures decoded instructions and resolves RAW hazards by forwarding from the EX and MEM stages.
- Detects load-use hazards and inserts bubbles.
- Presents registered A/B operands, the 3-bit ALU operation and the control bits that travel with them to the execute stage.

Parameters:
- DW, 16, datapath width (A, B, results)
- AW, 4, register address width (16 architectural registers, r0 reads as zero)
- SCW, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_op  in  3  ALU operation (000 add … 111 nop)
- id_rs_addr, id_rt_addr  in  AW  source register addresses
- id_rs_data, id_rt_data  in  DW  register-file read data (file is write-through, so WB needs no forwarding)
- id_imm  in  DW  extended immediate
- id_use_imm  in  1  B operand = id_imm instead of rt
- id_rt_used  in  1  instruction reads rt (stores and R-type)
- id_rd_addr  in  AW  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- ex_result  in  DW  ALU Out of the instruction currently held in this stage
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_rd_addr  in  AW  MEM-stage destination
- mem_result  in  DW  MEM-stage result
- hold  in  1  downstream stall: freeze all state
- flush  in  1  squash contents (branch redirect)
- stall_id  out  1  combinational: decode must hold its instruction
- ex_valid  out  1  registered instruction valid
- ex_op  out  3  registered ALU op
- ex_a, ex_b  out  DW  registered forwarded operands
- ex_rs_val_store  out  DW  forwarded rt value for stores
- ex_rd_addr  out  AW  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control
- ex_div_zero  out  1  registered: op = 011 and captured B = 0
- stall_count  out  SCW  number of bubble cycles inserted, saturating

Behaviour:
- Reset (async, rst = 1):
  - All registered outputs are 0 and ex_op = 111 (nop).
  - stall_count = 0.
  - stall_id is forced to 0 while rst is high.
- Forwarding, per source s in {rs, rt}, applied to the value captured on the clock edge. Priority order:
  1. If addr_s = 0, value = 0.
  2. Else if ex_valid & ex_reg_write & !ex_mem_read & ex_rd_addr = addr_s, value = ex_result.
  3. Else if mem_reg_write & mem_rd_addr = addr_s, value = mem_result.
  4. Else value = id_s_data.
- Operand selection:
  - A = fwd(rs).
  - B = id_use_imm ? id_imm : fwd(rt).
  - ex_rs_val_store = fwd(rt).
- Load-use hazard: lu = id_valid & ex_valid & ex_mem_read & ex_rd_addr ≠ 0 & (ex_rd_addr = id_rs_addr | (id_rt_used & ex_rd_addr = id_rt_addr)).
- stall_id = lu | hold.
- Update on each rising edge, highest priority first:
  1. flush: ex_valid ← 0, all control bits ← 0, ex_op ← 111. Flush wins over hold.
  2. hold: every register keeps its value and stall_count is unchanged.
  3. lu: insert a bubble. Register values are the same as for flush; stall_count increments, saturating at all-ones.
  4. Otherwise capture: ex_valid ← id_valid and the remaining fields from the forwarded values. When id_valid = 0, control bits are captured as 0 and ex_op as 111.
- Bubble timing: after a one-cycle bubble, the dependent instruction captures on the next edge, with the loaded value forwarded via mem_result.
- ex_div_zero is computed from the post-forwarding B and is registered alongside the other fields.
- Zero-cycle latency from ID inputs to stall_id; one cycle from ID inputs to ex_* outputs.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op constants: OP_ADD = 000, OP_SUB = 001, OP_MUL = 010, OP_DIV = 011, OP_AND = 100, OP_OR = 101, OP_ADDU = 110, OP_NOP = 111.
  - DW and AW.
  - A packed control struct (reg_write, mem_read, mem_write).
- One sub-module, fwd_unit: purely combinational forwarding select for one source, instantiated twice (rs, rt).

Test Plan:
- rst mid-operation with ex_valid = 1 -> all ex_* = 0 and ex_op = 111 immediately (asynchronous), without waiting for a clock edge; stall_count = 0.
- Back-to-back ADD r1 = r2+r3 (ex_result = 0x0005), then SUB r4 = r1-r3 with id_rs_data = 0x0000 -> ex_a = 0x0005.
- r1 written by both EX (0x0011) and MEM (0x0022), consumer reads r1 -> ex_a = 0x0011, EX priority.
- Load to r2 in EX, next instruction reads r2 -> stall_id = 1 for one cycle, bubble (ex_valid = 0, ex_op = 111), stall_count = 1. On the next edge with mem_result = 0xBEEF, ex_a = 0xBEEF.
- DIV with id_use_imm = 1, id_imm = 0 -> ex_div_zero = 1. Same op with imm = 0x0003 -> ex_div_zero = 0.
- hold and flush asserted together -> ex_valid = 0 after the edge. Hold alone for 3 cycles -> outputs frozen and stall_count unchanged.
- Destination r0 in EX with ex_result = 0x1234, consumer reads r0 -> ex_a = 0x0000 and no stall even when the EX instruction is a load.
